// File: rtl/alg_sched_pkg.sv
// Shared types for the ECG sample scheduler: FSM state encoding and the
// RR result record carried through the output FIFO.
package alg_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_e;

  localparam int unsigned RR_WIDTH      = 22;
  localparam int unsigned RR_FIFO_DEPTH = 4;
  localparam int unsigned RR_FIFO_PTR_W = $clog2(RR_FIFO_DEPTH);

  typedef struct packed {
    logic [RR_WIDTH-1:0] period;
    logic [RR_WIDTH-1:0] location;
  } rr_result_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and a registered head
// output that already shows the next entry in the cycle after a pop/push.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, rd_next;
  logic [PW:0]      count, count_next;
  logic             do_push, do_pop, head_is_new;

  always_comb begin
    do_pop      = pop & ~empty;
    do_push     = push & (~full | do_pop);
    rd_next     = rd_ptr + PW'(do_pop);
    count_next  = count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    // after this cycle the head is the entry being written right now
    head_is_new = (count == (PW+1)'(do_pop));
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_next;
      count  <= count_next;
      full   <= (count_next == FULL_CNT);
      empty  <= (count_next == '0);
      if (count_next != '0) dout <= head_is_new ? din : mem[rd_next];
    end
  end

endmodule

// File: rtl/alg_sample_scheduler.sv
// Paces ADC samples into alg_core at a fixed tick rate, sequences the core
// through warm-up/active/drain, and queues RR results on a valid/ready stream.
module alg_sample_scheduler
  import alg_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 11,
  parameter int unsigned CTR_WIDTH       = RR_WIDTH,
  parameter int unsigned CLK_DIV         = 1000,
  parameter int unsigned TIMEOUT_SAMPLES = 720,
  parameter int unsigned FIFO_DEPTH      = RR_FIFO_DEPTH
)(
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_enable,
  input  logic signed [DATA_WIDTH-1:0] i_adc_sample,
  input  logic                         i_adc_valid,
  output logic                         o_adc_ready,
  output logic                         o_ce,
  output logic signed [DATA_WIDTH-1:0] o_ecg_signal,
  output logic                         o_ecg_signal_valid,
  output logic [CTR_WIDTH-1:0]         o_ctr,
  input  logic [CTR_WIDTH-1:0]         i_rr_period,
  input  logic [CTR_WIDTH-1:0]         i_r_peak_location,
  input  logic                         i_rr_period_updated,
  input  logic                         i_th_initialised,
  output logic [CTR_WIDTH-1:0]         o_rr_data,
  output logic [CTR_WIDTH-1:0]         o_rr_loc,
  output logic                         o_rr_valid,
  input  logic                         i_rr_ready,
  output logic [1:0]                   o_state,
  output logic                         o_underrun,
  output logic                         o_overflow,
  output logic                         o_asystole
);

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam int unsigned AW = $clog2(TIMEOUT_SAMPLES + 1);
  localparam logic [AW-1:0] AS_LIMIT = AW'(TIMEOUT_SAMPLES);

  sched_state_e state_q, state_d;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] asys_cnt, asys_cnt_d;
  logic signed [DATA_WIDTH-1:0] hold_q;
  logic hold_full, hold_full_d;
  logic running, start, accept, tick, issue;
  logic rr_push, rr_pop, rr_drop, fifo_full, fifo_empty;
  rr_result_t rr_in, rr_head;

  always_comb begin
    running = (state_q == ST_WARMUP) || (state_q == ST_ACTIVE);
    start   = (state_q == ST_IDLE) && i_enable;
    accept  = i_adc_valid & o_adc_ready;
    tick    = running && (tick_cnt == TICK_LAST);
    // a sample accepted on the tick cycle is forwarded straight through
    issue   = tick & (hold_full | accept);
    hold_full_d = issue ? 1'b0 : (hold_full | accept);
    rr_pop  = ~fifo_empty & i_rr_ready;
    rr_push = i_rr_period_updated & (state_q != ST_IDLE);
    rr_drop = rr_push & fifo_full & ~rr_pop;

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_enable) state_d = ST_WARMUP;
      ST_WARMUP: if (!i_enable) state_d = ST_DRAIN;
                 else if (i_th_initialised) state_d = ST_ACTIVE;
      ST_ACTIVE: if (!i_enable) state_d = ST_DRAIN;
      ST_DRAIN:  if (fifo_empty) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    asys_cnt_d = asys_cnt;
    if ((state_q != ST_ACTIVE) || i_rr_period_updated) asys_cnt_d = '0;
    else if (o_ecg_signal_valid && (asys_cnt < AS_LIMIT)) asys_cnt_d = asys_cnt + AW'(1);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q            <= ST_IDLE;
      tick_cnt           <= '0;
      asys_cnt           <= '0;
      hold_q             <= '0;
      hold_full          <= 1'b0;
      o_adc_ready        <= 1'b0;
      o_ce               <= 1'b0;
      o_ecg_signal       <= '0;
      o_ecg_signal_valid <= 1'b0;
      o_ctr              <= '0;
      o_underrun         <= 1'b0;
      o_overflow         <= 1'b0;
      o_asystole         <= 1'b0;
    end else begin
      state_q            <= state_d;
      asys_cnt           <= asys_cnt_d;
      hold_full          <= hold_full_d;
      o_adc_ready        <= (state_d != ST_IDLE) & ~hold_full_d;
      o_ce               <= (state_d != ST_IDLE);
      o_ecg_signal_valid <= issue;
      o_asystole         <= (state_d == ST_ACTIVE) && (asys_cnt_d >= AS_LIMIT);
      if (accept) hold_q <= i_adc_sample;
      if (issue) o_ecg_signal <= hold_full ? hold_q : i_adc_sample;

      if (start) tick_cnt <= '0;
      else if (running) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);

      if (start) o_ctr <= '0;
      else if (o_ecg_signal_valid) o_ctr <= o_ctr + CTR_WIDTH'(1);

      if (start) o_underrun <= 1'b0;
      else if (tick && !hold_full && !accept) o_underrun <= 1'b1;

      if (start) o_overflow <= 1'b0;
      else if (rr_drop) o_overflow <= 1'b1;
    end
  end

  assign rr_in.period   = RR_WIDTH'(i_rr_period);
  assign rr_in.location = RR_WIDTH'(i_r_peak_location);

  sync_fifo #(
    .WIDTH ($bits(rr_result_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_rr_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .push  (rr_push),
    .pop   (rr_pop),
    .din   (rr_in),
    .dout  (rr_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign o_rr_valid = ~fifo_empty;
  assign o_rr_data  = CTR_WIDTH'(rr_head.period);
  assign o_rr_loc   = CTR_WIDTH'(rr_head.location);
  assign o_state    = state_q;

endmodule

// File: tb/tb_alg_sample_scheduler.sv
// Directed bench for alg_sample_scheduler: stimulus pushes expected strobes and
// RR results into queues, a negedge monitor pops and compares them.
module tb_alg_sample_scheduler;

  localparam int DW = 11;
  localparam int CW = 22;
  localparam int CLK_DIV = 4;

  logic clk = 1'b0;
  logic rst, en, adc_valid, rr_upd, th_init, rr_ready;
  logic signed [DW-1:0] adc_sample;
  logic [CW-1:0] rr_period, rr_loc_in;
  logic adc_ready, ce, ecg_valid, rr_valid, underrun, overflow, asystole;
  logic signed [DW-1:0] ecg;
  logic [CW-1:0] ctr, rr_data, rr_loc;
  logic [1:0] state;

  alg_sample_scheduler #(
    .DATA_WIDTH(DW), .CTR_WIDTH(CW), .CLK_DIV(CLK_DIV),
    .TIMEOUT_SAMPLES(3), .FIFO_DEPTH(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_enable(en),
    .i_adc_sample(adc_sample), .i_adc_valid(adc_valid), .o_adc_ready(adc_ready),
    .o_ce(ce), .o_ecg_signal(ecg), .o_ecg_signal_valid(ecg_valid), .o_ctr(ctr),
    .i_rr_period(rr_period), .i_r_peak_location(rr_loc_in),
    .i_rr_period_updated(rr_upd), .i_th_initialised(th_init),
    .o_rr_data(rr_data), .o_rr_loc(rr_loc), .o_rr_valid(rr_valid), .i_rr_ready(rr_ready),
    .o_state(state), .o_underrun(underrun), .o_overflow(overflow), .o_asystole(asystole)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int value; int idx; int cycle; } strobe_t;
  typedef struct { int period; int loc; } rr_t;
  strobe_t sq[$];
  rr_t     rq[$];
  int errors = 0;
  int checks = 0;
  int tick_base = 0;
  int exp_ctr = 0;

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (ecg_valid) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got value %0d ctr %0d, none expected (cycle %0d)", ecg, ctr, cyc);
        end else begin
          strobe_t s;
          s = sq.pop_front();
          chk("strobe_value", ecg, s.value);
          chk("strobe_ctr", ctr, s.idx);
          chk("strobe_cycle", cyc, s.cycle);
        end
      end
      if (rr_valid && rr_ready) begin
        if (rq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rr_pop: got period %0d, none expected (cycle %0d)", rr_data, cyc);
        end else begin
          rr_t r;
          r = rq.pop_front();
          chk("rr_period", rr_data, r.period);
          chk("rr_loc", rr_loc, r.loc);
        end
      end
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run();
    en = 1'b1;
    tick_base = cyc + 1 + CLK_DIV;
    exp_ctr = 0;
  endtask

  // Offer one sample; expected strobe lands on the first tick edge at or after acceptance.
  task automatic offer(int v);
    bit ok = 1'b0;
    int t;
    adc_sample = DW'(v);
    adc_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (adc_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL offer_timeout: sample %0d never accepted", v);
      adc_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      adc_valid = 1'b0;
      t = tick_base;
      while (t < cyc) t += CLK_DIV;
      sq.push_back('{v, exp_ctr, t});
      exp_ctr++;
    end
  endtask

  task automatic rr_pulse(int per, int loc, bit stored);
    rr_period = CW'(per);
    rr_loc_in = CW'(loc);
    rr_upd = 1'b1;
    step(1);
    rr_upd = 1'b0;
    if (stored) rq.push_back('{per, loc});
  endtask

  task automatic wait_sq_empty(int budget);
    for (int i = 0; i < budget && sq.size() != 0; i++) step(1);
    chk("strobes_done", sq.size(), 0);
  endtask

  task automatic wait_rq_empty(int budget);
    for (int i = 0; i < budget && rq.size() != 0; i++) step(1);
    chk("rr_done", rq.size(), 0);
  endtask

  task automatic wait_state(int s, int budget, string name);
    for (int i = 0; i < budget && state != 2'(s); i++) step(1);
    chk(name, state, s);
  endtask

  task automatic check_reset(string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_ce"}, ce, 0);
    chk({tag, "_ecg_valid"}, ecg_valid, 0);
    chk({tag, "_adc_ready"}, adc_ready, 0);
    chk({tag, "_rr_valid"}, rr_valid, 0);
    chk({tag, "_underrun"}, underrun, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_asystole"}, asystole, 0);
    chk({tag, "_ctr"}, ctr, 0);
    chk({tag, "_ecg"}, ecg, 0);
    chk({tag, "_rr_data"}, rr_data, 0);
    chk({tag, "_rr_loc"}, rr_loc, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; adc_valid = 1'b0; rr_upd = 1'b0;
    th_init = 1'b0; rr_ready = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    adc_sample = '0; rr_period = '0; rr_loc_in = '0;
    rst = 1'b1; en = 1'b0; adc_valid = 1'b0; rr_upd = 1'b0;
    th_init = 1'b0; rr_ready = 1'b0;
    step(2);
    check_reset("reset");
    rst = 1'b0;
    step(1);

    // startup: strobes at cycles 5, 9, 13 after enable, indices 0..2
    start_run();
    offer(5);
    offer(-3);
    offer(7);
    wait_sq_empty(40);
    chk("startup_state", state, 1);
    chk("startup_ctr", ctr, 3);
    chk("startup_underrun", underrun, 0);
    chk("startup_ce", ce, 1);

    // threshold ready and enable drop together: drain wins
    th_init = 1'b1; en = 1'b0;
    step(1);
    chk("drain_priority", state, 3);
    step(1);
    chk("drain_empty_idle", state, 0);
    chk("idle_ce", ce, 0);

    // underrun on first tick with no sample
    do_reset();
    start_run();
    step(4);
    chk("pre_tick_underrun", underrun, 0);
    step(1);
    chk("underrun_set", underrun, 1);
    chk("underrun_ctr", ctr, 0);
    step(4);
    chk("underrun_sticky", underrun, 1);
    chk("underrun_ctr_hold", ctr, 0);

    th_init = 1'b1;
    step(1);
    chk("warmup_exit", state, 2);

    // asystole after 3 strobes without an update
    offer(11);
    offer(22);
    chk("asystole_early", asystole, 0);
    offer(33);
    wait_sq_empty(40);
    chk("asystole_set", asystole, 1);
    rr_ready = 1'b1;
    rr_pulse(50, 500, 1'b1);
    chk("asystole_clear", asystole, 0);
    step(2);
    chk("rr_single_popped", rr_valid, 0);

    // FIFO fill, push+pop while full, overflow, ordered drain
    rr_ready = 1'b0;
    for (int i = 0; i < 4; i++) rr_pulse(100 + i, 1000 + i, 1'b1);
    chk("fifo_full_no_overflow", overflow, 0);
    chk("fifo_head", rr_data, 100);
    rr_ready = 1'b1;
    rr_pulse(104, 1004, 1'b1);
    rr_ready = 1'b0;
    chk("push_pop_full_no_overflow", overflow, 0);
    rr_pulse(105, 1005, 1'b0);
    chk("overflow_set", overflow, 1);
    rr_ready = 1'b1;
    wait_rq_empty(20);
    step(1);
    chk("fifo_drained", rr_valid, 0);

    // drain holds until queued results are consumed
    rr_ready = 1'b0;
    rr_pulse(300, 3000, 1'b1);
    rr_pulse(301, 3001, 1'b1);
    en = 1'b0;
    step(1);
    chk("drain_enter", state, 3);
    step(3);
    chk("drain_hold", state, 3);
    chk("drain_ce", ce, 1);
    rr_ready = 1'b1;
    wait_state(0, 10, "drain_to_idle");
    chk("drain_idle_ce", ce, 0);
    chk("drain_rr_empty", rq.size(), 0);
    th_init = 1'b0;

    // reset mid-ACTIVE with a held sample and a queued result
    do_reset();
    en = 1'b1; th_init = 1'b1; rr_ready = 1'b0;
    adc_sample = DW'(9); adc_valid = 1'b1;
    step(2);
    adc_valid = 1'b0;
    rr_period = CW'(77); rr_loc_in = CW'(777); rr_upd = 1'b1;
    step(1);
    rr_upd = 1'b0;
    chk("pre_reset_state", state, 2);
    chk("pre_reset_rr_valid", rr_valid, 1);
    chk("pre_reset_hold_full", adc_ready, 0);
    rst = 1'b1;
    step(1);
    check_reset("mid_reset");
    rst = 1'b0; en = 1'b0; th_init = 1'b0;
    step(CLK_DIV + 2);
    chk("post_reset_idle", state, 0);

    chk("final_strobe_queue", sq.size(), 0);
    chk("final_rr_queue", rq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alg_sample_scheduler.md
# alg_sample_scheduler

Front-end controller for `alg_core`. It paces raw ECG samples from the ADC interface into the core at a fixed sample rate and drives the core's clock-enable and sample counter. It sequences the core through warm-up and active detection, and buffers RR results into a valid/ready output stream. It sits between the ADC capture logic and the `alg_core` instance, and owns all of that instance's inputs.

## Interface
- `DATA_WIDTH`, 11: ECG sample width, signed.
- `CTR_WIDTH`, 22: sample counter and RR result width.
- `CLK_DIV`, 1000: clocks per sample tick; minimum 4.
- `TIMEOUT_SAMPLES`, 720: issued samples without an RR update before `o_asystole` asserts.
- `FIFO_DEPTH`, 4: RR result FIFO depth; power of two, ≥ 2.

Ports:
- `i_clk`  in  1  single clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_enable`  in  1  level; high runs acquisition, low stops it.
- `i_adc_sample`  in  DATA_WIDTH  signed raw sample.
- `i_adc_valid`  in  1  sample offered.
- `o_adc_ready`  out  1  hold register empty.
- `o_ce`  out  1  core clock-enable.
- `o_ecg_signal`  out  DATA_WIDTH  sample to core.
- `o_ecg_signal_valid`  out  1  one-cycle sample strobe to core.
- `o_ctr`  out  CTR_WIDTH  sample index to core.
- `i_rr_period`  in  CTR_WIDTH  RR period from core.
- `i_r_peak_location`  in  CTR_WIDTH  R-peak index from core.
- `i_rr_period_updated`  in  1  RR result strobe from core.
- `i_th_initialised`  in  1  core threshold ready.
- `o_rr_data`  out  CTR_WIDTH  FIFO head, period.
- `o_rr_loc`  out  CTR_WIDTH  FIFO head, location.
- `o_rr_valid`  out  1  FIFO non-empty.
- `i_rr_ready`  in  1  consumer ready.
- `o_state`  out  2  FSM state encoding.
- `o_underrun`  out  1  sticky: tick with no sample.
- `o_overflow`  out  1  sticky: result dropped.
- `o_asystole`  out  1  RR timeout.

## Operation
- FSM states: IDLE=0, WARMUP=1, ACTIVE=2, DRAIN=3.
  - IDLE → WARMUP when `i_enable`=1. Clears sticky flags, tick counter, `o_ctr` and asystole counter.
  - WARMUP → ACTIVE when `i_th_initialised`=1.
  - WARMUP or ACTIVE → DRAIN when `i_enable`=0. This takes priority over WARMUP → ACTIVE.
  - DRAIN → IDLE when the FIFO is empty. `i_enable` is ignored in DRAIN.
- `o_ce` = 1 in WARMUP, ACTIVE and DRAIN.
- Sample hold register: one entry. `o_adc_ready` = ~full. A sample is accepted on `i_adc_valid & o_adc_ready`. Accepted in any state except IDLE; in IDLE `o_adc_ready` is 0.
- Tick counter: counts 0..CLK_DIV-1 in WARMUP and ACTIVE only; a tick occurs at CLK_DIV-1.
  - On a tick with the hold register full: the next cycle has `o_ecg_signal_valid`=1 and `o_ecg_signal` = held value, and the hold register is emptied.
  - On a tick with the hold register empty: no strobe, `o_ctr` unchanged, `o_underrun` set.
- `o_ctr` holds the index of the sample being strobed, starting at 0. It increments the cycle after each strobe and wraps modulo 2^CTR_WIDTH.
- Results:
  - Each `i_rr_period_updated` pulse pushes {`i_rr_period`, `i_r_peak_location`} into the FIFO in any non-IDLE state.
  - Push while full and no pop: the result is dropped and `o_overflow` is set.
  - Push and pop in the same cycle while full: the push is accepted.
  - Pop on `o_rr_valid & i_rr_ready`.
- Asystole: in ACTIVE, a counter increments per strobe and resets to 0 on `i_rr_period_updated`.
  - `o_asystole` = 1 while the counter ≥ TIMEOUT_SAMPLES; the counter saturates there.
  - `o_asystole` clears on the next update or on leaving ACTIVE.

## Timing
- Reset values:
  - State IDLE; `o_state`=0.
  - Outputs `o_ce`, `o_ecg_signal_valid`, `o_adc_ready`, `o_rr_valid`, `o_underrun`, `o_overflow`, `o_asystole` = 0.
  - Data outputs `o_ctr`, `o_ecg_signal`, `o_rr_data`, `o_rr_loc` = 0.
  - FIFO empty.
- All outputs are registered.
- Latencies:
  - Tick → strobe: 1 cycle.
  - Strobe → `o_ctr` increment: 1 cycle.
  - `i_rr_period_updated` → `o_rr_valid`: 1 cycle when the FIFO was empty.
- The first tick occurs CLK_DIV cycles after entering WARMUP.
- Accept and tick in the same cycle: the sample is accepted into the register, then issued. The register was empty, so no tick-issue conflict arises.
- Reset mid-operation: all state returns to reset values on the next edge. FIFO contents and any pending sample are discarded.

## Structure
- Package `alg_sched_pkg`:
  - State enum `sched_state_e`, 2 bits.
  - Result struct `rr_result_t` {period, location}.
  - Localparam for FIFO pointer width, `$clog2(FIFO_DEPTH)`.
- Sub-module `sync_fifo`: parameterised width and depth, with push/pop, full/empty and registered head output. It is instantiated once for `rr_result_t`.

## Test plan
- Startup, CLK_DIV=4:
  - Stimulus: reset, `i_enable`=1, ADC offers samples 5, -3, 7.
  - Response: strobes at cycles 5, 9, 13 after enable with `o_ctr` = 0, 1, 2; `o_state` = 1.
- Underrun:
  - Stimulus: no sample presented before the first tick.
  - Response: no strobe, `o_underrun`=1 and stays set, `o_ctr` stays 0.
- Warm-up exit:
  - Stimulus: assert `i_th_initialised`.
  - Response: `o_state`=2 next cycle.
  - Stimulus: `i_enable`=0 in the same cycle.
  - Response: `o_state`=3.
- FIFO, FIFO_DEPTH=4:
  - Stimulus: 5 RR pulses with `i_rr_ready`=0.
  - Response: 4 stored, `o_overflow`=1.
  - Stimulus: push with a simultaneous pop while full.
  - Response: no overflow.
  - Stimulus: drain with `i_rr_ready`=1.
  - Response: values pop in order.
- Asystole, TIMEOUT_SAMPLES=3:
  - Stimulus: 3 strobes in ACTIVE with no RR update.
  - Response: `o_asystole`=1.
  - Stimulus: one RR pulse.
  - Response: `o_asystole`=0.
- Drain and reset:
  - Stimulus: `i_enable`=0 with 2 results queued.
  - Response: DRAIN is held until both are popped, then IDLE with `o_ce`=0.
  - Stimulus: `i_rst` asserted mid-ACTIVE.
  - Response: every output at its reset value next cycle.
